// File: rtl/bp_l15_req_arbiter_pkg.sv
// bp_l15_req_arbiter_pkg
// Shared definitions for the BlackParrot <-> OpenPiton L1.5 request arbiter:
// L1.5 request/return type codes, the fixed I-cache fill size, the sequencer
// state enum and the requester identity enum.
package bp_l15_req_arbiter_pkg;

  // L1.5 request types driven on transducer_l15_rqtype
  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;
  localparam logic [4:0] IMISS_RQ = 5'b10000;

  // L1.5 return types seen on l15_transducer_returntype
  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] INV_RET   = 4'b0011;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;

  // I-cache fills always fetch a full line
  localparam logic [2:0] ICACHE_SIZE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } owner_e;

  // Return type that completes the outstanding request of a given owner
  function automatic logic [3:0] expected_ret(owner_e owner, logic store);
    if (owner == OWN_ICACHE) return IFILL_RET;
    else if (store)          return ST_ACK;
    else                     return LOAD_RET;
  endfunction

endpackage

// File: rtl/bp_l15_req_arbiter_rr_arb2.sv
// bp_l15_rr_arb2
// Two-input round-robin arbiter with grant-and-advance.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   req_i[1:0]     : request vector (bit 0 = I-cache, bit 1 = D-cache)
//   advance_i      : a transaction owned by last_i has finished
//   last_i         : index of the requester that owned that transaction
//   grant_o[1:0]   : one-hot grant; with no request pending it points at the
//                    preferred requester so that one can see ready
module bp_l15_rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // rr_q = index of the currently preferred requester
  logic rr_q, rr_d;

  always_comb begin
    grant_o = rr_q ? 2'b10 : 2'b01;
    if (req_i == 2'b01) grant_o = 2'b01;
    if (req_i == 2'b10) grant_o = 2'b10;
  end

  // After a completion the other requester becomes preferred, so a held
  // request waits for at most one foreign transaction.
  always_comb begin
    rr_d = rr_q;
    if (advance_i) rr_d = ~last_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rr_q <= 1'b0;
    else         rr_q <= rr_d;
  end

endmodule

// File: rtl/bp_l15_req_arbiter.sv
// bp_l15_req_arbiter
// Shares one L1.5 transducer request/return channel between the BlackParrot
// I-cache and D-cache miss paths. One request is outstanding at a time:
// IDLE (arbitrate) -> SEND (drive request until ack) -> WAIT (consume returns
// until the matching one) -> RESP (present data until the owner's yumi).
// Ports:
//   clk_i, reset_i                       clock, async active-high reset
//   icache_req_* / dcache_req_*          miss request handshakes and payloads
//   icache_resp_* / dcache_resp_*        response handshakes (yumi style)
//   resp_data_o                          {data_1, data_0} of the matching return
//   transducer_l15_*                     request channel to the L1.5
//   l15_transducer_*                     return channel from the L1.5
//   transducer_l15_req_ack               return consumed
//   err_timeout_o                        sticky "L1.5 stopped responding" flag
//   state_o                              sequencer state, for observation
//
// Handshakes: a request transfers on a cycle where v_i & ready_o are both 1;
// ready_o never depends on a transfer completing and is 0 outside IDLE.
// A response is offered by resp_v_o and taken by the owner's resp_yumi_i in
// the same cycle; yumi is only meaningful while the matching resp_v_o is 1.
// The L1.5 request holds valid with stable fields until l15_transducer_ack.
module bp_l15_req_arbiter
  import bp_l15_req_arbiter_pkg::*;
#(
  parameter int addr_width_p = 40,
  parameter int timeout_p    = 1024
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    icache_req_v_i,
  output logic                    icache_req_ready_o,
  input  logic [addr_width_p-1:0] icache_req_addr_i,

  input  logic                    dcache_req_v_i,
  output logic                    dcache_req_ready_o,
  input  logic [addr_width_p-1:0] dcache_req_addr_i,
  input  logic                    dcache_req_store_i,
  input  logic [2:0]              dcache_req_size_i,
  input  logic [63:0]             dcache_req_data_i,

  output logic                    icache_resp_v_o,
  input  logic                    icache_resp_yumi_i,
  output logic                    dcache_resp_v_o,
  input  logic                    dcache_resp_yumi_i,
  output logic [127:0]            resp_data_o,

  output logic                    transducer_l15_val,
  output logic [4:0]              transducer_l15_rqtype,
  output logic [addr_width_p-1:0] transducer_l15_address,
  output logic [2:0]              transducer_l15_size,
  output logic [63:0]             transducer_l15_data,
  output logic                    transducer_l15_nc,
  input  logic                    l15_transducer_ack,

  input  logic                    l15_transducer_val,
  input  logic [3:0]              l15_transducer_returntype,
  input  logic [63:0]             l15_transducer_data_0,
  input  logic [63:0]             l15_transducer_data_1,
  output logic                    transducer_l15_req_ack,

  output logic                    err_timeout_o,
  output state_e                  state_o
);

  localparam int CNT_W = (timeout_p > 2) ? $clog2(timeout_p) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(timeout_p - 1);

  state_e                  state_q, state_d;
  owner_e                  own_q, own_d;
  logic                    store_q, store_d;
  logic [4:0]              rqtype_q, rqtype_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [2:0]              size_q, size_d;
  logic [63:0]             data_q, data_d;
  logic [127:0]            resp_data_q, resp_data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic [1:0] grant;
  logic       accept;
  logic       advance;
  logic       busy;
  logic       ret_match;

  bp_l15_rr_arb2 u_rr_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     ({dcache_req_v_i, icache_req_v_i}),
    .advance_i (advance),
    .last_i    (own_q),
    .grant_o   (grant)
  );

  assign ret_match = (l15_transducer_returntype == expected_ret(own_q, store_q));

  // Sequencer: next state, request/response register updates, handshakes
  always_comb begin
    state_d                = state_q;
    own_d                  = own_q;
    store_d                = store_q;
    rqtype_d               = rqtype_q;
    addr_d                 = addr_q;
    size_d                 = size_q;
    data_d                 = data_q;
    resp_data_d            = resp_data_q;
    icache_req_ready_o     = 1'b0;
    dcache_req_ready_o     = 1'b0;
    icache_resp_v_o        = 1'b0;
    dcache_resp_v_o        = 1'b0;
    transducer_l15_val     = 1'b0;
    transducer_l15_req_ack = 1'b0;
    accept                 = 1'b0;
    advance                = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        icache_req_ready_o = grant[0];
        dcache_req_ready_o = grant[1];
        if (icache_req_v_i && grant[0]) begin
          accept   = 1'b1;
          own_d    = OWN_ICACHE;
          store_d  = 1'b0;
          rqtype_d = IMISS_RQ;
          addr_d   = icache_req_addr_i;
          size_d   = ICACHE_SIZE;
          data_d   = '0;
          state_d  = ST_SEND;
        end else if (dcache_req_v_i && grant[1]) begin
          accept   = 1'b1;
          own_d    = OWN_DCACHE;
          store_d  = dcache_req_store_i;
          rqtype_d = dcache_req_store_i ? STORE_RQ : LOAD_RQ;
          addr_d   = dcache_req_addr_i;
          size_d   = dcache_req_size_i;
          data_d   = dcache_req_data_i;
          state_d  = ST_SEND;
        end
      end

      ST_SEND: begin
        transducer_l15_val = 1'b1;
        if (l15_transducer_ack) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // Every return is consumed; unrelated ones (interrupts,
        // invalidations) are simply dropped.
        transducer_l15_req_ack = l15_transducer_val;
        if (l15_transducer_val && ret_match) begin
          resp_data_d = {l15_transducer_data_1, l15_transducer_data_0};
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (own_q == OWN_ICACHE) begin
          icache_resp_v_o = 1'b1;
          if (icache_resp_yumi_i) begin
            advance = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          dcache_resp_v_o = 1'b1;
          if (dcache_resp_yumi_i) begin
            advance = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Timeout: counts cycles spent in SEND/WAIT for the current request,
  // saturating; the error stays set once the limit is reached.
  always_comb begin
    busy  = (state_q == ST_SEND) || (state_q == ST_WAIT);
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    err_d = err_q | (busy && (cnt_d == CNT_MAX));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      own_q       <= OWN_ICACHE;
      store_q     <= 1'b0;
      rqtype_q    <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      store_q     <= store_d;
      rqtype_q    <= rqtype_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      data_q      <= data_d;
      resp_data_q <= resp_data_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign transducer_l15_rqtype  = rqtype_q;
  assign transducer_l15_address = addr_q;
  assign transducer_l15_size    = size_q;
  assign transducer_l15_data    = data_q;
  assign transducer_l15_nc      = 1'b0;
  assign resp_data_o            = resp_data_q;
  assign err_timeout_o          = err_q;
  assign state_o                = state_q;

endmodule

// File: tb/tb_bp_l15_req_arbiter.sv
// Testbench for bp_l15_req_arbiter: directed and randomized transactions
// checked against a transaction-level model of the arbitration and L1.5
// protocol rules.
module tb_bp_l15_req_arbiter;
  import bp_l15_req_arbiter_pkg::*;

  localparam int AW = 40;
  localparam int TO = 16;

  localparam logic [3:0] R_LOAD  = 4'b0000;
  localparam logic [3:0] R_IFILL = 4'b0001;
  localparam logic [3:0] R_INV   = 4'b0011;
  localparam logic [3:0] R_STACK = 4'b0100;
  localparam logic [3:0] R_INT   = 4'b0111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          icache_req_v_i, icache_req_ready_o;
  logic [AW-1:0] icache_req_addr_i;
  logic          dcache_req_v_i, dcache_req_ready_o;
  logic [AW-1:0] dcache_req_addr_i;
  logic          dcache_req_store_i;
  logic [2:0]    dcache_req_size_i;
  logic [63:0]   dcache_req_data_i;
  logic          icache_resp_v_o, icache_resp_yumi_i;
  logic          dcache_resp_v_o, dcache_resp_yumi_i;
  logic [127:0]  resp_data_o;
  logic          transducer_l15_val;
  logic [4:0]    transducer_l15_rqtype;
  logic [AW-1:0] transducer_l15_address;
  logic [2:0]    transducer_l15_size;
  logic [63:0]   transducer_l15_data;
  logic          transducer_l15_nc;
  logic          l15_transducer_ack;
  logic          l15_transducer_val;
  logic [3:0]    l15_transducer_returntype;
  logic [63:0]   l15_transducer_data_0, l15_transducer_data_1;
  logic          transducer_l15_req_ack;
  logic          err_timeout_o;
  state_e        state_o;

  bp_l15_req_arbiter #(.addr_width_p(AW), .timeout_p(TO)) dut (
    .clk_i                     (clk),
    .reset_i                   (rst),
    .icache_req_v_i            (icache_req_v_i),
    .icache_req_ready_o        (icache_req_ready_o),
    .icache_req_addr_i         (icache_req_addr_i),
    .dcache_req_v_i            (dcache_req_v_i),
    .dcache_req_ready_o        (dcache_req_ready_o),
    .dcache_req_addr_i         (dcache_req_addr_i),
    .dcache_req_store_i        (dcache_req_store_i),
    .dcache_req_size_i         (dcache_req_size_i),
    .dcache_req_data_i         (dcache_req_data_i),
    .icache_resp_v_o           (icache_resp_v_o),
    .icache_resp_yumi_i        (icache_resp_yumi_i),
    .dcache_resp_v_o           (dcache_resp_v_o),
    .dcache_resp_yumi_i        (dcache_resp_yumi_i),
    .resp_data_o               (resp_data_o),
    .transducer_l15_val        (transducer_l15_val),
    .transducer_l15_rqtype     (transducer_l15_rqtype),
    .transducer_l15_address    (transducer_l15_address),
    .transducer_l15_size       (transducer_l15_size),
    .transducer_l15_data       (transducer_l15_data),
    .transducer_l15_nc         (transducer_l15_nc),
    .l15_transducer_ack        (l15_transducer_ack),
    .l15_transducer_val        (l15_transducer_val),
    .l15_transducer_returntype (l15_transducer_returntype),
    .l15_transducer_data_0     (l15_transducer_data_0),
    .l15_transducer_data_1     (l15_transducer_data_1),
    .transducer_l15_req_ack    (transducer_l15_req_ack),
    .err_timeout_o             (err_timeout_o),
    .state_o                   (state_o)
  );

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  bit rr_m;   // preferred requester: 0 = I-cache, 1 = D-cache
  bit err_m;  // sticky timeout expectation

  bit            pi_v;
  logic [AW-1:0] pi_addr;
  bit            pd_v;
  logic [AW-1:0] pd_addr;
  bit            pd_store;
  logic [2:0]    pd_size;
  logic [63:0]   pd_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    icache_req_v_i     = pi_v;
    icache_req_addr_i  = pi_addr;
    dcache_req_v_i     = pd_v;
    dcache_req_addr_i  = pd_addr;
    dcache_req_store_i = pd_store;
    dcache_req_size_i  = pd_size;
    dcache_req_data_i  = pd_data;
  endtask

  task automatic new_icache(input logic [AW-1:0] a);
    pi_v = 1'b1; pi_addr = a;
  endtask

  task automatic new_dcache(input logic [AW-1:0] a, input bit st, input logic [2:0] sz,
                            input logic [63:0] d);
    pd_v = 1'b1; pd_addr = a; pd_store = st; pd_size = sz; pd_data = d;
  endtask

  task automatic rand_addr(output logic [AW-1:0] a);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    a = r[AW-1:0];
  endtask

  // One full transaction; starts with the bench on a negedge in IDLE.
  task automatic run_txn(input int ack_dly, input int n_junk, input bit other_yumi,
                         input int yumi_dly);
    bit            own;
    bit            ld_store;
    int            cyc;
    logic [4:0]    e_rq;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_size;
    logic [63:0]   e_data;
    logic [3:0]    match_rt;
    logic [3:0]    junk_rt;
    logic [127:0]  d;

    if (!pi_v && !pd_v) new_icache(40'h00_0000_0040);
    drive_reqs();
    own = (pi_v && pd_v) ? rr_m : pd_v;
    #1;
    chk("state_idle", state_o, ST_IDLE);
    chk("icache_ready", icache_req_ready_o, own == 1'b0);
    chk("dcache_ready", dcache_req_ready_o, own == 1'b1);
    chk("l15_val_idle", transducer_l15_val, 1'b0);

    if (!own) begin
      e_rq = 5'b10000; e_addr = pi_addr; e_size = 3'b111; e_data = 64'h0;
      ld_store = 1'b0; match_rt = R_IFILL; pi_v = 1'b0;
    end else begin
      e_rq = pd_store ? 5'b00001 : 5'b00000; e_addr = pd_addr; e_size = pd_size;
      e_data = pd_data; ld_store = pd_store; match_rt = pd_store ? R_STACK : R_LOAD;
      pd_v = 1'b0;
    end

    @(negedge clk);
    drive_reqs();
    cyc = 0;
    #1;
    chk("ready_i_send", icache_req_ready_o, 1'b0);
    chk("ready_d_send", dcache_req_ready_o, 1'b0);
    chk("l15_val", transducer_l15_val, 1'b1);
    chk("rqtype", transducer_l15_rqtype, e_rq);
    chk("address", transducer_l15_address, e_addr);
    chk("size", transducer_l15_size, e_size);
    chk("data", transducer_l15_data, e_data);
    chk("nc", transducer_l15_nc, 1'b0);

    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      cyc++;
      if (cyc >= TO - 1) err_m = 1'b1;
      #1;
      chk("l15_val_hold", transducer_l15_val, 1'b1);
      chk("rqtype_hold", transducer_l15_rqtype, e_rq);
      chk("req_ack_send", transducer_l15_req_ack, 1'b0);
      chk("err_timeout", err_timeout_o, err_m);
    end

    l15_transducer_ack = 1'b1;
    @(negedge clk);
    cyc++;
    if (cyc >= TO - 1) err_m = 1'b1;
    l15_transducer_ack = 1'b0;
    #1;
    chk("state_wait", state_o, ST_WAIT);
    chk("l15_val_wait", transducer_l15_val, 1'b0);

    for (int j = 0; j < n_junk; j++) begin
      case (j % 3)
        0:       junk_rt = R_INT;
        1:       junk_rt = R_INV;
        default: junk_rt = !own ? R_LOAD : (ld_store ? R_LOAD : R_STACK);
      endcase
      l15_transducer_val        = 1'b1;
      l15_transducer_returntype = junk_rt;
      l15_transducer_data_0     = {$urandom(), $urandom()};
      l15_transducer_data_1     = {$urandom(), $urandom()};
      #1;
      chk("req_ack_junk", transducer_l15_req_ack, 1'b1);
      @(negedge clk);
      cyc++;
      if (cyc >= TO - 1) err_m = 1'b1;
      l15_transducer_val = 1'b0;
      #1;
      chk("icache_resp_v_junk", icache_resp_v_o, 1'b0);
      chk("dcache_resp_v_junk", dcache_resp_v_o, 1'b0);
      chk("state_wait_junk", state_o, ST_WAIT);
      chk("err_timeout_wait", err_timeout_o, err_m);
    end

    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_q.push_back(d);
    l15_transducer_val        = 1'b1;
    l15_transducer_returntype = match_rt;
    l15_transducer_data_1     = d[127:64];
    l15_transducer_data_0     = d[63:0];
    #1;
    chk("req_ack_match", transducer_l15_req_ack, 1'b1);
    @(negedge clk);
    cyc++;
    if (cyc >= TO - 1) err_m = 1'b1;
    // a stray return while in RESP must not be acknowledged
    l15_transducer_returntype = R_INT;
    #1;
    chk("icache_resp_v", icache_resp_v_o, own == 1'b0);
    chk("dcache_resp_v", dcache_resp_v_o, own == 1'b1);
    chk("resp_data", resp_data_o, exp_q.pop_front());
    chk("req_ack_resp", transducer_l15_req_ack, 1'b0);
    chk("ready_i_resp", icache_req_ready_o, 1'b0);
    chk("ready_d_resp", dcache_req_ready_o, 1'b0);
    chk("err_timeout_resp", err_timeout_o, err_m);
    l15_transducer_val = 1'b0;

    if (other_yumi) begin
      if (own) icache_resp_yumi_i = 1'b1;
      else     dcache_resp_yumi_i = 1'b1;
      @(negedge clk);
      icache_resp_yumi_i = 1'b0;
      dcache_resp_yumi_i = 1'b0;
      #1;
      chk("resp_v_other_yumi", own ? dcache_resp_v_o : icache_resp_v_o, 1'b1);
    end
    for (int y = 0; y < yumi_dly; y++) begin
      @(negedge clk);
      #1;
      chk("resp_v_hold", own ? dcache_resp_v_o : icache_resp_v_o, 1'b1);
    end

    if (own) dcache_resp_yumi_i = 1'b1;
    else     icache_resp_yumi_i = 1'b1;
    @(negedge clk);
    icache_resp_yumi_i = 1'b0;
    dcache_resp_yumi_i = 1'b0;
    rr_m = ~own;
    #1;
    chk("state_back_idle", state_o, ST_IDLE);
    chk("icache_resp_v_done", icache_resp_v_o, 1'b0);
    chk("dcache_resp_v_done", dcache_resp_v_o, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    pi_v = 1'b0; pi_addr = '0;
    pd_v = 1'b0; pd_addr = '0; pd_store = 1'b0; pd_size = 3'b0; pd_data = '0;
    drive_reqs();
    icache_resp_yumi_i = 1'b0;
    dcache_resp_yumi_i = 1'b0;
    l15_transducer_ack = 1'b0;
    l15_transducer_val = 1'b0;
    l15_transducer_returntype = 4'h0;
    l15_transducer_data_0 = '0;
    l15_transducer_data_1 = '0;
    rr_m = 1'b0;
    err_m = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_l15_val", transducer_l15_val, 1'b0);
    chk("rst_rqtype", transducer_l15_rqtype, 5'b0);
    chk("rst_addr", transducer_l15_address, '0);
    chk("rst_resp_data", resp_data_o, '0);
    chk("rst_err", err_timeout_o, 1'b0);
    chk("rst_icache_ready_pref", icache_req_ready_o, 1'b1);
    chk("rst_dcache_ready", dcache_req_ready_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // simultaneous after reset: I-cache first, held D-cache load next
    new_icache(40'h80_0000_1000);
    new_dcache(40'h00_1234_5678, 1'b0, 3'b011, 64'h1111_2222_3333_4444);
    run_txn(0, 0, 1'b1, 0);
    run_txn(1, 1, 1'b0, 1);

    // I-cache only, then a simultaneous pair where the store wins
    new_icache(40'h80_0000_2000);
    run_txn(2, 0, 1'b0, 0);
    new_icache(40'h80_0000_3000);
    new_dcache(40'h00_0000_BEE0, 1'b1, 3'b011, 64'h0000_0000_DEAD_BEEF);
    run_txn(0, 2, 1'b1, 0);
    run_txn(0, 3, 1'b0, 0);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      logic [AW-1:0] a;
      if (!pi_v && ($urandom_range(0, 1) == 1)) begin
        rand_addr(a);
        new_icache(a);
      end
      if (!pd_v && ($urandom_range(0, 1) == 1)) begin
        rand_addr(a);
        new_dcache(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   {$urandom(), $urandom()});
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2));
    end
    pi_v = 1'b0;
    pd_v = 1'b0;
    drive_reqs();

    // L1.5 withholds ack: error rises after TO-1 counted cycles and sticks
    new_icache(40'h80_0000_4000);
    run_txn(20, 1, 1'b0, 0);
    new_dcache(40'h00_0000_0100, 1'b0, 3'b010, 64'h5);
    run_txn(0, 0, 1'b0, 0);
    chk("err_sticky", err_timeout_o, 1'b1);

    // reset while in WAIT
    new_icache(40'h80_0000_5000);
    drive_reqs();
    @(negedge clk);
    pi_v = 1'b0;
    drive_reqs();
    l15_transducer_ack = 1'b1;
    @(negedge clk);
    l15_transducer_ack = 1'b0;
    #1;
    chk("pre_rst_state_wait", state_o, ST_WAIT);
    l15_transducer_val = 1'b1;
    l15_transducer_returntype = R_IFILL;
    rst = 1'b1;
    rr_m = 1'b0;
    err_m = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_state", state_o, ST_IDLE);
    chk("arst_req_ack", transducer_l15_req_ack, 1'b0);
    chk("arst_l15_val", transducer_l15_val, 1'b0);
    chk("arst_icache_resp_v", icache_resp_v_o, 1'b0);
    chk("arst_err", err_timeout_o, 1'b0);
    chk("arst_rqtype", transducer_l15_rqtype, 5'b0);
    chk("arst_addr", transducer_l15_address, '0);
    chk("arst_resp_data", resp_data_o, '0);
    chk("arst_icache_ready", icache_req_ready_o, 1'b1);
    l15_transducer_val = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    new_dcache(40'h00_0000_0200, 1'b1, 3'b001, 64'hA5);
    run_txn(1, 0, 1'b0, 0);
    chk("post_rst_err", err_timeout_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
